cache_arbiter: RTL and testbench
================================

CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 255, number of grant cycles without mem_ack/mem_rty before the transaction is aborted.
REQ-002 Reset is asynchronous and active-high; one clock. Ports, clock and reset first:
 clk  in  1  system clock
 rst  in  1  asynchronous active-high reset
 icache_cyc  in  1  I-cache bus cycle
 icache_stb  in  1  I-cache strobe
 icache_we  in  1  I-cache write enable
 icache_addr  in  16  I-cache line address
 icache_wdata  in  128  I-cache write line
 icache_ack  out  1  I-cache transfer done
 icache_rty  out  1  I-cache retry
 icache_rdata  out  128  read line to I-cache
 dcache_cyc, dcache_stb, dcache_we, dcache_addr, dcache_wdata  in  1/1/1/16/128  D-cache request, same meaning
 dcache_ack, dcache_rty  out  1  D-cache done / retry
 dcache_rdata  out  128  read line to D-cache
 mem_cyc, mem_stb, mem_we  out  1  physical memory handshake
 mem_addr  out  16  memory line address
 mem_wdata  out  128  memory write line
 mem_ack, mem_rty  in  1  memory done / retry
 mem_rdata  in  128  memory read line

Function
REQ-003 A port requests when its cyc & stb are both 1.
REQ-004 States: IDLE, GRANT_I, GRANT_D; state is registered.
REQ-005 IDLE: all mem_* outputs 0, all *_ack/*_rty 0.
REQ-006 IDLE, only one port requesting -> that port's GRANT state next cycle (one-cycle arbitration bubble).
REQ-007 IDLE, both requesting -> grant the port not recorded in last_grant (round-robin); last_grant updates on entering a GRANT state.
REQ-008 GRANT_x: mem_cyc/stb/we/addr/wdata combinationally equal owner's signals; non-owner inputs ignored.
REQ-009 GRANT_x: owner ack = mem_ack and owner rty = mem_rty, same cycle; non-owner ack/rty = 0.
REQ-010 mem_rdata drives icache_rdata and dcache_rdata unconditionally.
REQ-011 GRANT_x, mem_ack or mem_rty = 1 -> IDLE next cycle; mem_ack wins if both asserted.
REQ-012 GRANT_x, owner drops cyc or stb -> mem_cyc/mem_stb 0 that same cycle, IDLE next cycle, no ack/rty to owner.
REQ-013 Timeout counter (8-bit minimum, wide enough for TIMEOUT_CYCLES) clears on entering GRANT, increments each GRANT cycle without mem_ack/mem_rty.
REQ-014 Counter reaches TIMEOUT_CYCLES -> owner rty = 1 for that cycle, mem_cyc = 0, IDLE next cycle.
REQ-015 A port re-requesting in the cycle after its ack still passes through IDLE; with the other port waiting, the other port wins.

Reset
REQ-016 rst = 1 -> state IDLE, counter 0, last_grant = D (I-cache wins the first tie), all outputs 0 except rdata pass-through.
REQ-017 rst mid-transaction drops mem_cyc/mem_stb immediately, no ack/rty issued.

Structure
REQ-018 lc3b_types holds lc3b_word (16-bit), lc3b_line (128-bit) and the arbiter state enum; no new package.
REQ-019 No sub-module; the arbiter is a single flat module.

Verification
REQ-020 I reads 0x1000, D idle, mem_ack after 3 cycles -> IDLE 1 cycle, GRANT_I, icache_ack high 1 cycle with icache_rdata = mem_rdata, dcache_ack stays 0.
REQ-021 I and D request together after reset -> I served first, then D; a second tie -> D served first (last_grant = I).
REQ-022 D writes 0x2000 with data 0xDEAD..BEEF, mem_rty once -> dcache_rty 1 cycle, IDLE; D retries and gets dcache_ack.
REQ-023 D granted, D drops cyc before ack -> mem_cyc 0 that cycle, IDLE next, no dcache_ack.
REQ-024 TIMEOUT_CYCLES = 4, memory never responds -> icache_rty on the 4th grant cycle, mem_cyc 0, IDLE.
REQ-025 rst asserted mid-GRANT_D -> mem_cyc 0 asynchronously; after release, a tie grants I first.

Source files
------------

// File: rtl/lc3b_types.sv
// Shared LC-3b types: word/line widths and the cache arbiter state encoding.
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_line;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'b00,
    ARB_GRANT_I = 2'b01,
    ARB_GRANT_D = 2'b10
  } arb_state_t;

endpackage

// File: rtl/cache_arbiter.sv
// Round-robin I/D-cache to memory arbiter: one idle bubble per grant, owner handshake passes through combinationally.
// Backpressure: owner waits on mem_ack/mem_rty; a silent memory is aborted with rty after TIMEOUT_CYCLES grant cycles.
module cache_arbiter
  import lc3b_types::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     icache_cyc,
  input  logic     icache_stb,
  input  logic     icache_we,
  input  lc3b_word icache_addr,
  input  lc3b_line icache_wdata,
  output logic     icache_ack,
  output logic     icache_rty,
  output lc3b_line icache_rdata,
  input  logic     dcache_cyc,
  input  logic     dcache_stb,
  input  logic     dcache_we,
  input  lc3b_word dcache_addr,
  input  lc3b_line dcache_wdata,
  output logic     dcache_ack,
  output logic     dcache_rty,
  output lc3b_line dcache_rdata,
  output logic     mem_cyc,
  output logic     mem_stb,
  output logic     mem_we,
  output lc3b_word mem_addr,
  output lc3b_line mem_wdata,
  input  logic     mem_ack,
  input  logic     mem_rty,
  input  lc3b_line mem_rdata
);

  localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  arb_state_t    state, state_nxt;
  logic          last_grant_d;
  logic [CW-1:0] cnt;

  logic     i_req, d_req, granted, owner_req, mem_resp, timeout;
  logic     own_cyc, own_stb, own_we, owner_ack, owner_rty;
  lc3b_word own_addr;
  lc3b_line own_wdata;

  assign i_req        = icache_cyc & icache_stb;
  assign d_req        = dcache_cyc & dcache_stb;
  assign granted      = (state == ARB_GRANT_I) || (state == ARB_GRANT_D);
  assign mem_resp     = mem_ack | mem_rty;
  assign icache_rdata = mem_rdata;
  assign dcache_rdata = mem_rdata;

  always_comb begin
    own_cyc   = 1'b0;
    own_stb   = 1'b0;
    own_we    = 1'b0;
    own_addr  = '0;
    own_wdata = '0;
    case (state)
      ARB_GRANT_I: begin
        own_cyc   = icache_cyc;
        own_stb   = icache_stb;
        own_we    = icache_we;
        own_addr  = icache_addr;
        own_wdata = icache_wdata;
      end
      ARB_GRANT_D: begin
        own_cyc   = dcache_cyc;
        own_stb   = dcache_stb;
        own_we    = dcache_we;
        own_addr  = dcache_addr;
        own_wdata = dcache_wdata;
      end
      default: ;
    endcase
  end

  assign owner_req = granted & own_cyc & own_stb;
  // Abort only when the memory is silent on the last allowed grant cycle.
  assign timeout   = owner_req & ~mem_resp & (cnt == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    mem_cyc   = 1'b0;
    mem_stb   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    owner_ack = 1'b0;
    owner_rty = 1'b0;
    if (owner_req) begin
      mem_cyc   = ~timeout;
      mem_stb   = ~timeout;
      mem_we    = own_we;
      mem_addr  = own_addr;
      mem_wdata = own_wdata;
      owner_ack = mem_ack;
      owner_rty = (mem_rty & ~mem_ack) | timeout;
    end
  end

  assign icache_ack = owner_ack & (state == ARB_GRANT_I);
  assign icache_rty = owner_rty & (state == ARB_GRANT_I);
  assign dcache_ack = owner_ack & (state == ARB_GRANT_D);
  assign dcache_rty = owner_rty & (state == ARB_GRANT_D);

  always_comb begin
    state_nxt = state;
    case (state)
      ARB_IDLE: begin
        if (i_req && (!d_req || last_grant_d)) state_nxt = ARB_GRANT_I;
        else if (d_req)                        state_nxt = ARB_GRANT_D;
      end
      ARB_GRANT_I, ARB_GRANT_D: begin
        if (!owner_req || mem_resp || timeout) state_nxt = ARB_IDLE;
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ARB_IDLE;
      last_grant_d <= 1'b1;
      cnt          <= '0;
    end else begin
      state <= state_nxt;
      if (state == ARB_IDLE && state_nxt != ARB_IDLE) begin
        last_grant_d <= (state_nxt == ARB_GRANT_D);
        cnt          <= '0;
      end else if (granted && !mem_resp) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed-vector bench for cache_arbiter, built with TIMEOUT_CYCLES = 4.
module tb_cache_arbiter;
  import lc3b_types::*;

  logic     clk = 1'b0;
  logic     rst;
  logic     icache_cyc, icache_stb, icache_we;
  lc3b_word icache_addr;
  lc3b_line icache_wdata, icache_rdata;
  logic     icache_ack, icache_rty;
  logic     dcache_cyc, dcache_stb, dcache_we;
  lc3b_word dcache_addr;
  lc3b_line dcache_wdata, dcache_rdata;
  logic     dcache_ack, dcache_rty;
  logic     mem_cyc, mem_stb, mem_we;
  lc3b_word mem_addr;
  lc3b_line mem_wdata, mem_rdata;
  logic     mem_ack, mem_rty;

  int checks = 0;
  int passes = 0;

  // {mem_cyc, mem_stb, icache_ack, icache_rty, dcache_ack, dcache_rty}
  logic [5:0] ctl;
  assign ctl = {mem_cyc, mem_stb, icache_ack, icache_rty, dcache_ack, dcache_rty};

  cache_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .icache_cyc(icache_cyc), .icache_stb(icache_stb), .icache_we(icache_we),
    .icache_addr(icache_addr), .icache_wdata(icache_wdata),
    .icache_ack(icache_ack), .icache_rty(icache_rty), .icache_rdata(icache_rdata),
    .dcache_cyc(dcache_cyc), .dcache_stb(dcache_stb), .dcache_we(dcache_we),
    .dcache_addr(dcache_addr), .dcache_wdata(dcache_wdata),
    .dcache_ack(dcache_ack), .dcache_rty(dcache_rty), .dcache_rdata(dcache_rdata),
    .mem_cyc(mem_cyc), .mem_stb(mem_stb), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rty(mem_rty), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    icache_cyc = 0; icache_stb = 0; icache_we = 0; icache_addr = '0; icache_wdata = '0;
    dcache_cyc = 0; dcache_stb = 0; dcache_we = 0; dcache_addr = '0; dcache_wdata = '0;
    mem_ack = 0; mem_rty = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    step();
    rst = 0;
    step();
  endtask

  task automatic test_reset();
    clear_inputs();
    mem_rdata = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    rst = 1;
    icache_cyc = 1; icache_stb = 1; icache_addr = 16'h1234;
    #2;
    checks++; if (ctl !== 6'b0) $display("FAIL reset_ctl: got %b want %b", ctl, 6'b0); else passes++;
    checks++; if ({mem_we, mem_addr} !== 17'h0) $display("FAIL reset_mem: got %h want 0", {mem_we, mem_addr}); else passes++;
    checks++; if (icache_rdata !== mem_rdata || dcache_rdata !== mem_rdata)
      $display("FAIL reset_rdata: got %h/%h want %h", icache_rdata, dcache_rdata, mem_rdata); else passes++;
    step();
    checks++; if (ctl !== 6'b0) $display("FAIL reset_held: got %b want %b", ctl, 6'b0); else passes++;
    rst = 0;
    clear_inputs();
    step();
  endtask

  task automatic test_read_i();
    icache_cyc = 1; icache_stb = 1; icache_addr = 16'h1000;
    #1;
    checks++; if (ctl !== 6'b000000) $display("FAIL read_bubble: got %b want %b", ctl, 6'b000000); else passes++;
    step();
    checks++; if (ctl !== 6'b110000 || mem_addr !== 16'h1000 || mem_we !== 1'b0)
      $display("FAIL read_grant1: got %b/%h want 110000/1000", ctl, mem_addr); else passes++;
    step();
    checks++; if (ctl !== 6'b110000) $display("FAIL read_grant2: got %b want %b", ctl, 6'b110000); else passes++;
    step();
    mem_ack = 1; mem_rdata = 128'hAAAA_5555_0000_FFFF_1234_5678_9ABC_DEF0;
    #1;
    checks++; if (ctl !== 6'b111000) $display("FAIL read_ack: got %b want %b", ctl, 6'b111000); else passes++;
    checks++; if (icache_rdata !== 128'hAAAA_5555_0000_FFFF_1234_5678_9ABC_DEF0)
      $display("FAIL read_rdata: got %h", icache_rdata); else passes++;
    step();
    mem_ack = 0; icache_cyc = 0; icache_stb = 0;
    #1;
    checks++; if (ctl !== 6'b000000) $display("FAIL read_idle: got %b want %b", ctl, 6'b000000); else passes++;
    step();
  endtask

  task automatic test_tie();
    do_reset();
    icache_cyc = 1; icache_stb = 1; icache_addr = 16'h0100;
    dcache_cyc = 1; dcache_stb = 1; dcache_addr = 16'h0200; dcache_we = 1;
    #1;
    checks++; if (ctl !== 6'b0) $display("FAIL tie_bubble: got %b want 0", ctl); else passes++;
    step();
    checks++; if (ctl !== 6'b110000 || mem_addr !== 16'h0100 || mem_we !== 1'b0)
      $display("FAIL tie_first_i: got %b/%h want 110000/0100", ctl, mem_addr); else passes++;
    mem_ack = 1;
    #1;
    checks++; if (ctl !== 6'b111000) $display("FAIL tie_i_ack: got %b want %b", ctl, 6'b111000); else passes++;
    step();
    mem_ack = 0;
    #1;
    checks++; if (ctl !== 6'b0) $display("FAIL tie_idle1: got %b want 0", ctl); else passes++;
    step();
    // I re-requested right after its ack; D was waiting and must win.
    checks++; if (ctl !== 6'b110000 || mem_addr !== 16'h0200 || mem_we !== 1'b1)
      $display("FAIL tie_second_d: got %b/%h/%b want 110000/0200/1", ctl, mem_addr, mem_we); else passes++;
    icache_addr = 16'h0FFF;
    #1;
    checks++; if (mem_addr !== 16'h0200) $display("FAIL tie_nonowner: got %h want 0200", mem_addr); else passes++;
    mem_ack = 1;
    #1;
    checks++; if (ctl !== 6'b110010) $display("FAIL tie_d_ack: got %b want %b", ctl, 6'b110010); else passes++;
    step();
    mem_ack = 0;
    step();
    checks++; if (ctl !== 6'b110000 || mem_addr !== 16'h0FFF)
      $display("FAIL tie_third_i: got %b/%h want 110000/0fff", ctl, mem_addr); else passes++;
    clear_inputs();
    step();
  endtask

  task automatic test_write_retry();
    do_reset();
    dcache_cyc = 1; dcache_stb = 1; dcache_we = 1; dcache_addr = 16'h2000;
    dcache_wdata = 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF;
    step();
    checks++; if (ctl !== 6'b110000 || mem_we !== 1'b1 || mem_addr !== 16'h2000 ||
                  mem_wdata !== 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF)
      $display("FAIL wr_grant: got %b/%b/%h/%h", ctl, mem_we, mem_addr, mem_wdata); else passes++;
    mem_rty = 1;
    #1;
    checks++; if (ctl !== 6'b110001) $display("FAIL wr_rty: got %b want %b", ctl, 6'b110001); else passes++;
    step();
    mem_rty = 0;
    #1;
    checks++; if (ctl !== 6'b0) $display("FAIL wr_idle: got %b want 0", ctl); else passes++;
    step();
    mem_ack = 1;
    #1;
    checks++; if (ctl !== 6'b110010) $display("FAIL wr_retry_ack: got %b want %b", ctl, 6'b110010); else passes++;
    step();
    clear_inputs();
    step();
  endtask

  task automatic test_drop();
    dcache_cyc = 1; dcache_stb = 1; dcache_addr = 16'h3000;
    step();
    checks++; if (ctl !== 6'b110000) $display("FAIL drop_grant: got %b want %b", ctl, 6'b110000); else passes++;
    step();
    dcache_cyc = 0; mem_ack = 1;
    #1;
    checks++; if (ctl !== 6'b0) $display("FAIL drop_same_cycle: got %b want 0", ctl); else passes++;
    step();
    mem_ack = 0;
    #1;
    checks++; if (ctl !== 6'b0) $display("FAIL drop_idle: got %b want 0", ctl); else passes++;
    step();
    checks++; if (ctl !== 6'b0) $display("FAIL drop_stays_idle: got %b want 0", ctl); else passes++;
    clear_inputs();
  endtask

  task automatic test_timeout();
    logic [4:0] obs;
    icache_cyc = 1; icache_stb = 1; icache_addr = 16'h4000;
    step();
    for (int c = 1; c <= 3; c++) begin
      checks++; if (ctl !== 6'b110000) $display("FAIL timeout_wait%0d: got %b want 110000", c, ctl); else passes++;
      step();
    end
    obs = {mem_cyc, icache_ack, icache_rty, dcache_ack, dcache_rty};
    checks++; if (obs !== 5'b00100) $display("FAIL timeout_rty: got %b want 00100", obs); else passes++;
    step();
    checks++; if (ctl !== 6'b0) $display("FAIL timeout_idle: got %b want 0", ctl); else passes++;
    step();
    // Counter must restart on the new grant.
    for (int c = 1; c <= 3; c++) begin
      checks++; if (ctl !== 6'b110000) $display("FAIL timeout_rearm%0d: got %b want 110000", c, ctl); else passes++;
      step();
    end
    clear_inputs();
    step();
    step();
  endtask

  task automatic test_reset_mid();
    do_reset();
    dcache_cyc = 1; dcache_stb = 1; dcache_addr = 16'h5000;
    step();
    checks++; if (ctl !== 6'b110000 || mem_addr !== 16'h5000)
      $display("FAIL rstmid_grant: got %b/%h", ctl, mem_addr); else passes++;
    #2;
    rst = 1; mem_ack = 1;
    #1;
    checks++; if (ctl !== 6'b0) $display("FAIL rstmid_async: got %b want 0", ctl); else passes++;
    step();
    mem_ack = 0;
    #2;
    rst = 0;
    icache_cyc = 1; icache_stb = 1; icache_addr = 16'h6000;
    step();
    checks++; if (ctl !== 6'b110000 || mem_addr !== 16'h6000)
      $display("FAIL rstmid_tie_i: got %b/%h want 110000/6000", ctl, mem_addr); else passes++;
    clear_inputs();
    step();
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    mem_rdata = '0;
    test_reset();
    test_read_i();
    test_tie();
    test_write_retry();
    test_drop();
    test_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
